// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_seq_pkg;

    // Instruction phase of the sequencer
    typedef enum logic [2:0] {
        INIT   = 3'd0,
        READ   = 3'd1,
        ISSUE  = 3'd2,
        UPDATE = 3'd3,
        HALT   = 3'd4
    } pc_state_e;

    localparam int unsigned DEFAULT_WIDTH        = 16;
    localparam int unsigned DEFAULT_STEP         = 1;
    localparam int unsigned DEFAULT_RESET_VECTOR = 0;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: same-cycle branch strobe, then a captured branch,
// then cur_pc + STEP. The increment is formed one bit wider so the carry
// can be reported; carry is only meaningful when the increment is chosen.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned STEP  = DEFAULT_STEP
) (
    input  logic             bypass_valid,
    input  logic [WIDTH-1:0] bypass_target,
    input  logic             pend_valid,
    input  logic [WIDTH-1:0] pend_target,
    input  logic [WIDTH-1:0] cur_pc,
    output logic [WIDTH-1:0] next_pc,
    output logic             inc_carry
);

    logic [WIDTH:0] inc_sum;

    assign inc_sum = {1'b0, cur_pc} + (WIDTH+1)'(STEP);

    // Priority mux; branch targets never raise the carry
    always_comb begin
        next_pc   = inc_sum[WIDTH-1:0];
        inc_carry = inc_sum[WIDTH];
        if (bypass_valid) begin
            next_pc   = bypass_target;
            inc_carry = 1'b0;
        end else if (pend_valid) begin
            next_pc   = pend_target;
            inc_carry = 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the PC storage register through a
// READ -> ISSUE -> UPDATE loop and hands each PC to fetch over valid/ready.
// Optional feature: define PC_SEQ_OVERFLOW_TRAP_EN to halt with TRAP=1 when
// the increment carries out of WIDTH bits; otherwise the PC wraps.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned      HEIGHT       = 1,
    parameter int unsigned      PC_INDEX     = 0,
    parameter int unsigned      STEP         = DEFAULT_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL,
    input  logic              BRANCH_VALID,
    input  logic [WIDTH-1:0]  BRANCH_TARGET,
    input  logic              FETCH_READY,
    output logic              FETCH_VALID,
    output logic [WIDTH-1:0]  FETCH_ADDR,
    output logic              PC_WRITE_ENABLE,
    output logic              PC_READ_ENABLE,
    output logic [HEIGHT-1:0] PC_ADDRESS,
    output logic [WIDTH-1:0]  PC_WDATA,
    input  logic [WIDTH-1:0]  PC_RDATA,
    output logic              TRAP
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] cur_pc_q, cur_pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    // Outputs must be idle while reset is held, so INIT only acts once the
    // first clock edge after release has been seen.
    logic             init_armed_q, init_armed_d;

    logic [WIDTH-1:0] next_pc;
    logic             inc_carry;
    logic             trap_hit;

    logic             fetch_valid;
    logic [WIDTH-1:0] fetch_addr;
    logic             pc_we;
    logic             pc_re;
    logic [WIDTH-1:0] pc_wdata;

    pc_next_calc #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .bypass_valid  (BRANCH_VALID),
        .bypass_target (BRANCH_TARGET),
        .pend_valid    (pend_valid_q),
        .pend_target   (pend_target_q),
        .cur_pc        (cur_pc_q),
        .next_pc       (next_pc),
        .inc_carry     (inc_carry)
    );

`ifdef PC_SEQ_OVERFLOW_TRAP_EN
    assign trap_hit = inc_carry;
    assign TRAP     = (state_q == HALT);
`else
    logic carry_unused;
    assign carry_unused = inc_carry;
    assign trap_hit     = 1'b0;
    assign TRAP         = 1'b0;
`endif

    // State and datapath registers; reset is asynchronous, active-low
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= INIT;
            cur_pc_q      <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            init_armed_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_pc_q      <= cur_pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            init_armed_q  <= init_armed_d;
        end
    end

    // Next-state, branch capture and storage/fetch controls
    always_comb begin
        state_d       = state_q;
        cur_pc_d      = cur_pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        init_armed_d  = 1'b1;
        fetch_valid   = 1'b0;
        fetch_addr    = '0;
        pc_we         = 1'b0;
        pc_re         = 1'b0;
        pc_wdata      = '0;

        // A strobe outside UPDATE is remembered; in UPDATE it is bypassed
        // straight into the write instead.
        if (BRANCH_VALID && (state_q != UPDATE)) begin
            pend_valid_d  = 1'b1;
            pend_target_d = BRANCH_TARGET;
        end

        case (state_q)
            INIT: begin
                if (init_armed_q) begin
                    pc_we    = 1'b1;
                    pc_wdata = RESET_VECTOR;
                    state_d  = READ;
                end
            end
            READ: begin
                if (!STALL) begin
                    pc_re    = 1'b1;
                    cur_pc_d = PC_RDATA;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Address is held steady until accepted; stall has no effect
                fetch_valid = 1'b1;
                fetch_addr  = cur_pc_q;
                if (FETCH_READY) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (!STALL) begin
                    if (trap_hit) begin
                        state_d = HALT;
                    end else begin
                        pc_we        = 1'b1;
                        pc_wdata     = next_pc;
                        pend_valid_d = 1'b0;
                        state_d      = READ;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign FETCH_VALID     = fetch_valid;
    assign FETCH_ADDR      = fetch_addr;
    assign PC_WRITE_ENABLE = pc_we;
    assign PC_READ_ENABLE  = pc_re;
    assign PC_WDATA        = pc_wdata;
    assign PC_ADDRESS      = HEIGHT'(PC_INDEX);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of per-cycle inputs and expected
// outputs, plus hand sequences for branch-in-INIT and reset mid-ISSUE.
module tb_pc_sequencer;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         STALL = 1'b0;
    logic         BRANCH_VALID = 1'b0;
    logic [W-1:0] BRANCH_TARGET = '0;
    logic         FETCH_READY = 1'b0;
    logic         FETCH_VALID;
    logic [W-1:0] FETCH_ADDR;
    logic         PC_WRITE_ENABLE;
    logic         PC_READ_ENABLE;
    logic [0:0]   PC_ADDRESS;
    logic [W-1:0] PC_WDATA;
    logic [W-1:0] PC_RDATA;
    logic         TRAP;

    // PC storage model: no reset of its own, combinational read
    logic [W-1:0] store_q = 16'hDEAD;

    pc_sequencer #(
        .WIDTH        (W),
        .HEIGHT       (1),
        .PC_INDEX     (0),
        .STEP         (1),
        .RESET_VECTOR (16'h0010)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .STALL           (STALL),
        .BRANCH_VALID    (BRANCH_VALID),
        .BRANCH_TARGET   (BRANCH_TARGET),
        .FETCH_READY     (FETCH_READY),
        .FETCH_VALID     (FETCH_VALID),
        .FETCH_ADDR      (FETCH_ADDR),
        .PC_WRITE_ENABLE (PC_WRITE_ENABLE),
        .PC_READ_ENABLE  (PC_READ_ENABLE),
        .PC_ADDRESS      (PC_ADDRESS),
        .PC_WDATA        (PC_WDATA),
        .PC_RDATA        (PC_RDATA),
        .TRAP            (TRAP)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (PC_WRITE_ENABLE) store_q <= PC_WDATA;
    end
    assign PC_RDATA = store_q;

    typedef struct {
        logic         stall;
        logic         bv;
        logic [W-1:0] bt;
        logic         rdy;
        logic         v;
        logic [W-1:0] a;
        logic         we;
        logic         re;
        logic [W-1:0] wd;
        logic         t;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic add(input logic s, input logic bv, input logic [W-1:0] bt, input logic r,
                       input logic v, input logic [W-1:0] a, input logic we, input logic re,
                       input logic [W-1:0] wd, input logic t);
        vec_t e;
        e = '{s, bv, bt, r, v, a, we, re, wd, t};
        vecs.push_back(e);
    endtask

    task automatic check_outs(input string name, input vec_t e);
        n_cmp++;
        if (FETCH_VALID !== e.v || FETCH_ADDR !== e.a || PC_WRITE_ENABLE !== e.we ||
            PC_READ_ENABLE !== e.re || PC_WDATA !== e.wd || TRAP !== e.t || PC_ADDRESS !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got valid=%b addr=%h we=%b re=%b wdata=%h trap=%b adr=%b, expected valid=%b addr=%h we=%b re=%b wdata=%h trap=%b adr=0",
                     name, FETCH_VALID, FETCH_ADDR, PC_WRITE_ENABLE, PC_READ_ENABLE, PC_WDATA, TRAP, PC_ADDRESS,
                     e.v, e.a, e.we, e.re, e.wd, e.t);
        end else begin
            $display("  %s: valid=%b addr=%h we=%b re=%b wdata=%h trap=%b",
                     name, FETCH_VALID, FETCH_ADDR, PC_WRITE_ENABLE, PC_READ_ENABLE, PC_WDATA, TRAP);
        end
    endtask

    // One clock: drive inputs just after the edge, compare on the falling edge
    task automatic step(input string tag, input vec_t e);
        @(posedge CLK);
        #1;
        STALL         = e.stall;
        BRANCH_VALID  = e.bv;
        BRANCH_TARGET = e.bt;
        FETCH_READY   = e.rdy;
        cyc++;
        @(negedge CLK);
        check_outs($sformatf("%s c%0d", tag, cyc), e);
    endtask

    task automatic idle_inputs();
        STALL         = 1'b0;
        BRANCH_VALID  = 1'b0;
        BRANCH_TARGET = '0;
        FETCH_READY   = 1'b0;
    endtask

    // Hold reset two cycles, check idle outputs, release just after an edge
    task automatic do_reset(input string tag);
        vec_t z;
        z = '{1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0};
        RST = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_outs({tag, " in reset"}, z);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cyc = 0;
    endtask

    task automatic run_queue(input string tag);
        foreach (vecs[i]) step(tag, vecs[i]);
        vecs.delete();
    endtask

    initial begin
        vec_t z;
        z = '{1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0};

        // ---------------- main table ----------------
        //   stall bv bt       rdy   v  addr     we re wdata    trap
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0010, 0);   // c1 INIT
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c2 READ
        add(0, 0, 16'h0000, 1,  1, 16'h0010, 0, 0, 16'h0000, 0);   // c3 ISSUE
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0011, 0);   // c4 UPDATE
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c5 READ
        for (int i = 0; i < 5; i++)
            add(0, 0, 16'h0000, 0, 1, 16'h0011, 0, 0, 16'h0000, 0); // c6-10 not ready
        add(0, 0, 16'h0000, 1,  1, 16'h0011, 0, 0, 16'h0000, 0);   // c11 accept
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0012, 0);   // c12
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c13
        add(0, 1, 16'h0200, 1,  1, 16'h0012, 0, 0, 16'h0000, 0);   // c14 branch in ISSUE
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0200, 0);   // c15
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c16
        add(0, 0, 16'h0000, 1,  1, 16'h0200, 0, 0, 16'h0000, 0);   // c17
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0201, 0);   // c18
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c19
        add(0, 1, 16'h0300, 0,  1, 16'h0201, 0, 0, 16'h0000, 0);   // c20 first branch
        add(0, 1, 16'h0400, 1,  1, 16'h0201, 0, 0, 16'h0000, 0);   // c21 last wins
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0400, 0);   // c22
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c23
        add(0, 0, 16'h0000, 1,  1, 16'h0400, 0, 0, 16'h0000, 0);   // c24
        add(0, 1, 16'h0500, 1,  0, 16'h0000, 1, 0, 16'h0500, 0);   // c25 bypass in UPDATE
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c26
        add(0, 0, 16'h0000, 1,  1, 16'h0500, 0, 0, 16'h0000, 0);   // c27
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0501, 0);   // c28 nothing pending
        for (int i = 0; i < 3; i++)
            add(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0); // c29-31 stalled READ
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c32
        add(0, 0, 16'h0000, 1,  1, 16'h0501, 0, 0, 16'h0000, 0);   // c33
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0502, 0);   // c34
        add(0, 1, 16'hFFFF, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c35 branch in READ
        add(0, 0, 16'h0000, 1,  1, 16'h0502, 0, 0, 16'h0000, 0);   // c36
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'hFFFF, 0);   // c37
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c38
        add(0, 0, 16'h0000, 1,  1, 16'hFFFF, 0, 0, 16'h0000, 0);   // c39
`ifdef PC_SEQ_OVERFLOW_TRAP_EN
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 0, 16'h0000, 0);   // c40 write suppressed
        for (int i = 0; i < 3; i++)
            add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 1); // c41-43 HALT
`else
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0000, 0);   // c40 wrap
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);   // c41
        add(0, 0, 16'h0000, 1,  1, 16'h0000, 0, 0, 16'h0000, 0);   // c42
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0001, 0);   // c43
`endif
        do_reset("main");
        run_queue("main");

        // ---------------- branch in INIT, then reset mid-ISSUE ----------------
        add(0, 1, 16'h0123, 1,  0, 16'h0000, 1, 0, 16'h0010, 0);   // INIT, branch held
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);
        add(0, 0, 16'h0000, 1,  1, 16'h0010, 0, 0, 16'h0000, 0);
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0123, 0);   // applied at first UPDATE
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);
        add(0, 1, 16'h0777, 0,  1, 16'h0123, 0, 0, 16'h0000, 0);   // ISSUE, branch pending
        do_reset("init_br");
        run_queue("init_br");

        // Asynchronous reset in the middle of a clock period
        #1;
        RST = 1'b0;
        idle_inputs();
        #1;
        check_outs("async reset", z);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cyc = 0;
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0010, 0);
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 0, 1, 16'h0000, 0);
        add(0, 0, 16'h0000, 1,  1, 16'h0010, 0, 0, 16'h0000, 0);
        add(0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 16'h0011, 0);   // pending branch lost
        run_queue("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control-side master for the program-counter storage register: owns the read/write enables, address and write data of that register and turns it into a running instruction-address stream for the fetch stage. Each instruction is a three-phase cycle: read the stored PC, issue it to fetch over a valid/ready handshake, then write back the next PC (increment or branch redirect). It sits between the PC storage block and the fetch unit.

## Interface
- WIDTH, 16, PC width in bits; matches storage DATA width
- HEIGHT, 1, storage address width
- PC_INDEX, 0, storage entry holding the PC (constant on PC_ADDRESS)
- STEP, 1, increment applied per issued instruction
- RESET_VECTOR, 0, PC value written after reset
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-low
- STALL  in  1  freezes the FSM in READ/UPDATE; no enables asserted while high
- BRANCH_VALID  in  1  single-cycle redirect strobe
- BRANCH_TARGET  in  WIDTH  redirect address, sampled with BRANCH_VALID
- FETCH_READY  in  1  fetch accepts FETCH_ADDR
- FETCH_VALID  out  1  FETCH_ADDR valid
- FETCH_ADDR  out  WIDTH  instruction address to fetch
- PC_WRITE_ENABLE  out  1  to storage WRITE_ENABLE
- PC_READ_ENABLE  out  1  to storage READ_ENABLE
- PC_ADDRESS  out  HEIGHT  to storage ADDRESS, always PC_INDEX
- PC_WDATA  out  WIDTH  to storage DATA_IN
- PC_RDATA  in  WIDTH  from storage DATA_OUT (combinational read)
- TRAP  out  1  PC overflow trap (only with PC_SEQ_OVERFLOW_TRAP_EN; else tied 0)

## Operation
- States: INIT, READ, ISSUE, UPDATE, HALT.
- INIT (one cycle after reset release): PC_WRITE_ENABLE=1, PC_WDATA=RESET_VECTOR -> READ. Independent of storage's own reset.
- READ: PC_READ_ENABLE=1; cur_pc <= PC_RDATA at cycle end -> ISSUE. STALL high: hold, enables low.
- ISSUE: FETCH_VALID=1, FETCH_ADDR=cur_pc; hold until FETCH_VALID && FETCH_READY -> UPDATE. Address never changes or retracts while valid; STALL ignored here.
- UPDATE: PC_WRITE_ENABLE=1, PC_WDATA=next -> READ. STALL high: hold, enables low.
- next priority: BRANCH_VALID in this cycle (bypass) > pending branch > cur_pc+STEP.
- Branch capture: BRANCH_VALID in any state except UPDATE loads pending register (last strobe wins); pending cleared when consumed in UPDATE. Branch in INIT is held and applied at first UPDATE.
- Increment computed in WIDTH+1 bits; carry = overflow. Branch targets never overflow.
- Read and write enables never asserted in the same cycle.

## Timing
- Reset (async assert): FETCH_VALID=0, FETCH_ADDR=0, PC_WRITE_ENABLE=0, PC_READ_ENABLE=0, PC_WDATA=0, TRAP=0, pending cleared, state INIT. PC_ADDRESS=PC_INDEX always.
- Reset release at edge 0: INIT write at cycle 1, READ cycle 2, first FETCH_VALID cycle 3.
- Steady state with FETCH_READY=1, no stall: one issue per 3 cycles.
- Storage latches PC_WDATA on the edge ending UPDATE; READ on the following cycle sees it.
- Reset mid-operation: outputs drop to reset values immediately; pending branch lost; restart from INIT.

## Configuration
- PC_SEQ_OVERFLOW_TRAP_EN defined: increment carry in UPDATE suppresses the write, enters HALT, TRAP=1 from next cycle; HALT keeps FETCH_VALID=0 and enables low until reset. Pending/bypass branch in that UPDATE takes priority (no trap).
- Undefined: increment wraps modulo 2^WIDTH; HALT unreachable; TRAP tied 0.

## Structure
- Package pc_seq_pkg: state enum (INIT, READ, ISSUE, UPDATE, HALT), default STEP and RESET_VECTOR constants.
- Sub-module pc_next_calc: combinational next-PC mux (bypass/pending/increment) with carry output; FSM and registers in pc_sequencer.

## Test plan
- RESET_VECTOR=0x0010, FETCH_READY=1 -> write 0x0010 in cycle 1; FETCH_ADDR 0x0010, 0x0011, 0x0012 at cycles 3, 6, 9.
- FETCH_READY low 5 cycles during ISSUE at 0x0011 -> FETCH_VALID/FETCH_ADDR stable, no enables, write 0x0012 one cycle after READY.
- BRANCH_VALID with 0x0200 during ISSUE at 0x0011 -> UPDATE writes 0x0200; fetch sequence 0x0200, 0x0201.
- Branch 0x0300 then 0x0400 before UPDATE; separately branch 0x0500 in UPDATE cycle -> writes 0x0400, later 0x0500 bypassed, pending empty after.
- Branch to 0xFFFF, then issue -> without macro next fetch 0x0000; with macro TRAP=1, no write, FETCH_VALID stays 0.
- STALL high 3 cycles in READ, then RST low mid-ISSUE -> no enables while stalled; all outputs 0 immediately on reset; restart at RESET_VECTOR.
